// File: rtl/setting_sequencer_if.sv
// Bus between the clock-board host logic and the setting sequencer.
// Handshake: every request (start/next/cancel/tick) is a one-cycle valid
// strobe with no ready; the sequencer decides on the edge it samples it,
// and every result (field_wr/commit/aborted/err) is a one-cycle valid
// strobe the host must take in that cycle, with no backpressure.
interface setting_sequencer_if #(
  parameter int NUM_TARGETS = 3,
  parameter int MAX_STEPS   = 4,
  parameter int FIELD_W     = 7
);
  localparam int SW = $clog2(MAX_STEPS);
  localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  logic [NUM_TARGETS-1:0]    start;
  logic                      next;
  logic                      cancel;
  logic                      tick;
  logic [NUM_TARGETS*SW-1:0] steps_cfg;
  logic [FIELD_W-1:0]        sw_in;
  logic [FIELD_W-1:0]        lim_in;
  logic                      busy;
  logic [TW-1:0]             cur_target;
  logic [SW-1:0]             cur_step;
  logic                      field_wr;
  logic [SW-1:0]             field_idx;
  logic [FIELD_W-1:0]        field_data;
  logic [NUM_TARGETS-1:0]    commit;
  logic                      aborted;
  logic                      err;
  logic [1:0]                dbg_state;

  modport master (
    output start, next, cancel, tick, steps_cfg, sw_in, lim_in,
    input  busy, cur_target, cur_step, field_wr, field_idx, field_data,
           commit, aborted, err, dbg_state
  );

  modport slave (
    input  start, next, cancel, tick, steps_cfg, sw_in, lim_in,
    output busy, cur_target, cur_step, field_wr, field_idx, field_data,
           commit, aborted, err, dbg_state
  );
endinterface

// File: rtl/setting_sequencer.sv
// Multi-field setting entry controller: one field per accepted "next",
// range-checked against a host limit, with cancel and an inactivity timeout.
module setting_sequencer #(
  parameter int NUM_TARGETS = 3,
  parameter int MAX_STEPS   = 4,
  parameter int FIELD_W     = 7,
  parameter int TIMEOUT_S   = 10
) (
  input  logic clk,
  input  logic rst,
  setting_sequencer_if.slave bus
);
  localparam int SW = $clog2(MAX_STEPS);
  localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_S);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic [TW-1:0]          r_cur_target;
  logic [SW-1:0]          r_cur_step;
  logic                   r_field_wr;
  logic [SW-1:0]          r_field_idx;
  logic [FIELD_W-1:0]     r_field_data;
  logic [NUM_TARGETS-1:0] r_commit;
  logic                   r_aborted;
  logic                   r_err;
  logic [7:0]             r_cnt;

  logic [TW-1:0] w_start_idx;
  logic [SW-1:0] w_last_step;
  logic [7:0]    w_cnt_inc;
  logic          w_field_ok;
  logic          w_timeout;

  // Lowest-indexed requesting target wins when several start together.
  always_comb begin
    w_start_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (bus.start[i]) w_start_idx = TW'(i);
    end
  end

  // steps_cfg is read live every cycle, never latched.
  assign w_last_step = bus.steps_cfg[int'(r_cur_target) * SW +: SW];
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_field_ok  = (bus.sw_in <= bus.lim_in);
  // A tick that completes the timeout beats a simultaneous next.
  assign w_timeout   = (TIMEOUT_S != 0) && bus.tick && (w_cnt_inc == TIMEOUT_CNT);

  // Entry FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_cur_target <= '0;
      r_cur_step   <= '0;
      r_field_wr   <= 1'b0;
      r_field_idx  <= '0;
      r_field_data <= '0;
      r_commit     <= '0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_field_wr <= 1'b0;
      r_commit   <= '0;
      r_aborted  <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= |bus.start;
          if (|bus.start) begin
            r_state      <= S_ENTRY;
            r_cur_target <= w_start_idx;
            r_cur_step   <= '0;
            r_cnt        <= '0;
          end
        end
        S_ENTRY: begin
          if (bus.cancel || w_timeout) begin
            r_aborted  <= 1'b1;
            r_busy     <= 1'b0;
            r_cur_step <= '0;
            r_state    <= S_IDLE;
          end else if (bus.next && w_field_ok) begin
            r_field_wr   <= 1'b1;
            r_field_idx  <= r_cur_step;
            r_field_data <= bus.sw_in;
            r_cnt        <= '0;
            if (r_cur_step == w_last_step) r_state <= S_COMMIT;
            else r_cur_step <= r_cur_step + 1'b1;
          end else begin
            // Rejected next raises err; any tick still counts.
            if (bus.next) r_err <= 1'b1;
            if (bus.tick) r_cnt <= w_cnt_inc;
          end
        end
        S_COMMIT: begin
          // commit follows the final field_wr by one cycle; busy drops after.
          r_commit   <= NUM_TARGETS'(1) << r_cur_target;
          r_cur_step <= '0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.cur_target = r_cur_target;
  assign bus.cur_step   = r_cur_step;
  assign bus.field_wr   = r_field_wr;
  assign bus.field_idx  = r_field_idx;
  assign bus.field_data = r_field_data;
  assign bus.commit     = r_commit;
  assign bus.aborted    = r_aborted;
  assign bus.err        = r_err;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_setting_sequencer.sv
// Directed bench for setting_sequencer with a field-write scoreboard.
module tb_setting_sequencer;
  localparam int NT = 3;
  localparam int MS = 4;
  localparam int FW = 7;
  localparam int TO = 3;
  localparam int W  = 2 + FW;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  setting_sequencer_if #(.NUM_TARGETS(NT), .MAX_STEPS(MS), .FIELD_W(FW)) bus ();

  setting_sequencer #(
    .NUM_TARGETS(NT), .MAX_STEPS(MS), .FIELD_W(FW), .TIMEOUT_S(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each field_wr must match the next expected {idx, data}.
  always @(negedge clk) begin
    if (rst && bus.field_wr) begin
      if (exp_q.size() == 0) check("field_wr_unexpected", 1, 0);
      else check("field_wr", {bus.field_idx, bus.field_data}, exp_q.pop_front());
    end
  end

  // Driver tasks: advance one clock, inputs change #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start  = '0;
    bus.next   = 1'b0;
    bus.cancel = 1'b0;
    bus.tick   = 1'b0;
  endtask

  task automatic do_start(input logic [NT-1:0] s);
    bus.start = s;
    step();
    bus.start = '0;
  endtask

  task automatic do_next(input logic [FW-1:0] sw, input logic [FW-1:0] lim, input logic [1:0] idx);
    bus.sw_in  = sw;
    bus.lim_in = lim;
    bus.next   = 1'b1;
    if (sw <= lim) exp_q.push_back({idx, sw});
    step();
    bus.next = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    bus.steps_cfg = 6'b11_10_01;  // t0 last=1, t1 last=2, t2 last=3
    bus.sw_in     = '0;
    bus.lim_in    = '0;
    rst = 1'b0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_target", bus.cur_target, 0);
    check("rst_step", bus.cur_step, 0);
    check("rst_strobes", {bus.field_wr, bus.commit, bus.aborted, bus.err}, 0);
    check("rst_state", bus.dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Target 0, two fields, commit one cycle after the last field_wr.
    do_start(3'b001);
    check("t0_busy", bus.busy, 1);
    check("t0_target", bus.cur_target, 0);
    do_next(7'd14, 7'd23, 2'd0);
    check("t0_step1", bus.cur_step, 1);
    do_next(7'd37, 7'd59, 2'd1);
    check("t0_wr_last", bus.field_wr, 1);
    check("t0_no_commit_yet", bus.commit, 0);
    step();
    check("t0_commit", bus.commit, 3'b001);
    check("t0_busy_commit", bus.busy, 1);
    step();
    check("t0_commit_drop", bus.commit, 0);
    check("t0_busy_drop", bus.busy, 0);

    // Priority start, range error, ignored start during entry.
    do_start(3'b110);
    check("t1_target", bus.cur_target, 1);
    do_next(7'd13, 7'd12, 2'd0);
    check("t1_err", bus.err, 1);
    check("t1_err_no_wr", bus.field_wr, 0);
    check("t1_err_step", bus.cur_step, 0);
    step();
    check("t1_err_one_cycle", bus.err, 0);
    do_next(7'd4, 7'd12, 2'd0);
    check("t1_step1", bus.cur_step, 1);
    do_start(3'b100);
    check("t1_start_ignored", bus.cur_target, 1);
    check("t1_still_busy", bus.busy, 1);

    // Cancel beats a valid next.
    bus.cancel = 1'b1;
    bus.sw_in  = 7'd5;
    bus.lim_in = 7'd12;
    bus.next   = 1'b1;
    step();
    clear_inputs();
    check("cancel_aborted", bus.aborted, 1);
    check("cancel_no_wr", bus.field_wr, 0);
    check("cancel_state", bus.dbg_state, 0);
    check("cancel_busy", bus.busy, 0);
    step();
    check("cancel_one_cycle", bus.aborted, 0);

    // Timeout after three idle ticks.
    do_start(3'b001);
    do_tick();
    step();
    do_tick();
    check("to_not_yet", bus.aborted, 0);
    do_tick();
    check("to_aborted", bus.aborted, 1);
    check("to_no_commit", bus.commit, 0);
    check("to_busy", bus.busy, 0);

    // An accepted next restarts the timeout count.
    do_start(3'b001);
    do_tick();
    do_tick();
    do_next(7'd3, 7'd9, 2'd0);
    do_tick();
    check("to_rst_1", bus.aborted, 0);
    do_tick();
    check("to_rst_2", bus.aborted, 0);
    do_tick();
    check("to_rst_3", bus.aborted, 1);

    // Target 2 uses the top step index MAX_STEPS-1.
    do_start(3'b100);
    check("t2_target", bus.cur_target, 2);
    for (int i = 0; i < 4; i++) begin
      do_next(7'(10 + i), 7'd99, 2'(i));
    end
    check("t2_step_max", bus.cur_step, 3);
    step();
    check("t2_commit", bus.commit, 3'b100);

    // Asynchronous reset mid-entry.
    step();
    do_start(3'b001);
    bus.sw_in  = 7'd7;
    bus.lim_in = 7'd9;
    bus.next   = 1'b1;
    step();
    bus.next = 1'b0;
    check("arst_pre_wr", bus.field_wr, 1);
    check("arst_pre_step", bus.cur_step, 1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_strobes", {bus.field_wr, bus.commit, bus.aborted, bus.err}, 0);
    check("arst_step", bus.cur_step, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    do_start(3'b010);
    check("arst_restart_step", bus.cur_step, 0);
    check("arst_restart_target", bus.cur_target, 1);
    do_next(7'd2, 7'd9, 2'd0);
    check("arst_restart_step1", bus.cur_step, 1);
    step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/setting_sequencer.md
Name: setting_sequencer

Overview:
- Parametrised multi-field entry controller for the clock test board. It collects hour/min, year/month/day, alarm and similar settings one field per button press from the switch bank.
- Generalises the fixed three-target, hard-coded-step input FSM:
  - NUM_TARGETS targets, each with a per-target step count.
  - Range validation of every field against a host-supplied limit.
  - Cancel, and an inactivity timeout counted in 1 Hz ticks.
  - A one-cycle commit strobe per target, used for the time/date/alarm overwrite signals.

Parameters:
- NUM_TARGETS, 3, number of settable targets (1..8).
- MAX_STEPS, 4, maximum fields per target (power of two, 2..16).
- FIELD_W, 7, width of one field value.
- TIMEOUT_S, 10, seconds of inactivity before an entry is aborted (1..255; 0 disables the timeout).
- SW = $clog2(MAX_STEPS) and TW = $clog2(NUM_TARGETS) (minimum 1) are derived localparams.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  NUM_TARGETS  debounced one-cycle request per target
- next  in  1  debounced one-cycle "accept field" strobe
- cancel  in  1  debounced one-cycle abort strobe
- tick  in  1  one-cycle 1 Hz strobe (from the 1 Hz generator, edge-converted)
- steps_cfg  in  NUM_TARGETS*SW  per-target last step index; slice t is bits [t*SW +: SW]
- sw_in  in  FIELD_W  current field value from switches
- lim_in  in  FIELD_W  host combinational max for (cur_target, cur_step)
- busy  out  1  high while an entry is in progress
- cur_target  out  TW  active target index
- cur_step  out  SW  active field index
- field_wr  out  1  one-cycle write strobe for an accepted field
- field_idx  out  SW  index of the written field
- field_data  out  FIELD_W  value of the written field
- commit  out  NUM_TARGETS  one-hot, one-cycle; the target's buffer is complete
- aborted  out  1  one-cycle; entry dropped by cancel or timeout
- err  out  1  one-cycle; next pressed with sw_in > lim_in

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, cur_target=0, cur_step=0, timeout counter=0.
  - Mid-entry reset discards the entry with no commit and no aborted pulse.
- States: IDLE, ENTRY, COMMIT.
- IDLE:
  - Any start bit set → ENTRY next cycle.
  - cur_target = lowest set start index; cur_step=0; timeout counter cleared.
  - next, cancel and tick are ignored.
- ENTRY:
  - busy=1. Per-cycle priority: cancel > timeout > next. start is ignored.
  - cancel → aborted=1 for one cycle, then IDLE.
  - tick → counter += 1. When the counter reaches TIMEOUT_S on a tick: aborted=1, then IDLE.
  - next with sw_in > lim_in (unsigned compare) → err=1 for one cycle. Step, counter and state are unchanged.
  - next with sw_in <= lim_in → in the same clock edge: field_wr=1, field_idx=cur_step, field_data=sw_in (registered, valid exactly in the field_wr cycle). The counter is cleared.
    - If cur_step == steps_cfg slice of cur_target → COMMIT.
    - Otherwise cur_step += 1.
  - next together with tick: the accepted next clears the counter and the tick is dropped. A rejected next leaves the tick counted.
- COMMIT:
  - One cycle: commit[cur_target]=1, busy=1. Then IDLE, with cur_step cleared.
  - start in this cycle is ignored.
- Step arithmetic:
  - cur_step never exceeds the configured last index.
  - A steps_cfg slice is sampled every cycle, not latched. It must be held stable during entry; on a change, the comparison uses the new value.
  - Index MAX_STEPS-1 is legal; no wrap occurs.
- Latency:
  - start → busy: 1 cycle.
  - Final next → commit: 1 cycle after field_wr.
  - Commit → busy=0: 1 cycle.
- Strobe outputs field_wr, commit, aborted and err are never high for more than one cycle per event. No two of commit, aborted and err assert in the same cycle.

Test Plan:
- Reset, then start=3'b001 with steps_cfg[0]=1, lim_in=23, sw_in=14, next; then lim_in=59, sw_in=37, next → field_wr(0,14), then field_wr(1,37), commit=3'b001 one cycle later, busy=0 on the following cycle.
- Target 1 with steps_cfg=2: sw_in=13, lim_in=12, next → err=1, cur_step stays 0. Then sw_in=4, next → field_wr(0,4), cur_step=1.
- start=3'b110 in the same cycle → cur_target=1. A later start=3'b100 during ENTRY is ignored.
- In ENTRY with TIMEOUT_S=3, no next: 3 ticks → aborted=1 on the third tick, no commit. With next accepted between tick 2 and tick 3: no abort until 3 further ticks.
- cancel and valid next in the same cycle → aborted=1, field_wr=0, state IDLE.
- rst low mid-entry (cur_step=1) → busy=0, all strobes 0 immediately and asynchronously. After release, start begins again at step 0.
